// File: rtl/muldiv_unit_if.sv
// Issue/result interface of the iterative multiply/divide unit.
// The master side (ID/EX stage) issues operations and MTHI/MTLO writes;
// the slave side (muldiv_unit) reports busy/done and exposes HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, flush, hi_we, lo_we, write_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush, hi_we, lo_we, write_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operates on operand magnitudes: one shift-add (multiply) or one restoring
// shift-subtract (divide) step per cycle for WIDTH cycles, then a FIX cycle
// applies the recorded signs and writes HI/LO. op: 00 MULT, 01 MULTU,
// 10 DIV, 11 DIVU (op[1] selects divide, op[0] selects unsigned).
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_busy;
  logic             r_done;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Operand magnitudes and signs; only signed ops see a negative operand.
  assign w_signed = ~bus.op[0];
  assign w_a_neg  = w_signed & bus.operand_a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.operand_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.operand_a : bus.operand_a;
  assign w_b_mag  = w_b_neg ? -bus.operand_b : bus.operand_b;

  // Multiply step: {r_acc, r_q} is the partial product, r_q[0] the next multiplier bit.
  assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);

  // Divide step: r_acc is the partial remainder, r_q shifts dividend out and quotient in.
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  // Sign correction. A zero divisor yields remainder |a|, which the remainder
  // sign (sign of a) turns back into the original dividend; quotient is forced to all ones.
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -r_q : r_q);
  assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  // Control FSM, datapath iteration and HI/LO ownership with registered busy/done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.hi_we) r_hi <= bus.write_data;
          if (bus.lo_we) r_lo <= bus.write_data;
          if (bus.start && !bus.flush) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_acc    <= '0;
            r_q      <= w_a_mag;
            r_b      <= w_b_mag;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= bus.op[1] & (bus.operand_b == '0);
          end
        end
        RUN: begin
          if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            if (r_is_div) begin
              if (!w_diff[WIDTH]) begin
                r_acc <= w_diff[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], 1'b1};
              end else begin
                r_acc <= w_shift[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], 1'b0};
              end
            end else begin
              r_acc <= w_sum[WIDTH:1];
              r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
              r_state <= FIX;
              r_done  <= 1'b1;
            end
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (!bus.flush) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo} results,
// a monitor pops and compares one cycle after each done pulse.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  logic [63:0] expQ[$];

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Issue one operation and track busy/done timing cycle by cycle.
  // flushAt>0 asserts flush during that cycle; poke injects a start at cycle 5
  // and an MTLO write at cycle 8, both of which must be ignored.
  task automatic applyStimulus(input logic [1:0] opc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input int flushAt,
                               input bit poke);
    int busyCnt;
    int doneCnt;
    int doneAt;
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = 0;
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.op = opc;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    if (flushAt == 0) expQ.push_back({expHi, expLo});
    for (int k = 1; k <= 60; k++) begin
      if (poke && k == 5) begin
        bus.start = 1'b1;
        bus.op = OP_MULTU;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd9;
      end
      if (poke && k == 8) begin
        bus.lo_we = 1'b1;
        bus.write_data = 32'hAA;
      end
      if (k == flushAt) bus.flush = 1'b1;
      @(negedge clock);
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        doneCnt++;
        doneAt = k;
      end
      if (!bus.busy) break;
      @(posedge clock); #1;
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
      bus.flush = 1'b0;
    end
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    bus.flush = 1'b0;
    checkOutput("busy_cycles", 64'(busyCnt), (flushAt == 0) ? 64'd33 : 64'(flushAt));
    checkOutput("done_pulses", 64'(doneCnt), (flushAt == 0) ? 64'd1 : 64'd0);
    if (flushAt == 0) checkOutput("done_cycle", 64'(doneAt), 64'd33);
  endtask

  // Monitor: on a done pulse, compare HI/LO in the following cycle against the scoreboard.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp = expQ.pop_front();
          @(negedge clock);
          checkOutput("result_hi", {32'd0, bus.hi}, {32'd0, exp[63:32]});
          checkOutput("result_lo", {32'd0, bus.lo}, {32'd0, exp[31:0]});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.write_data = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, bus.lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1'b0);
    applyStimulus(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1'b0);
    applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0);
    applyStimulus(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1'b0);
    applyStimulus(OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 0, 1'b0);
    applyStimulus(OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 0, 1'b0);
    applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0, 1'b0);
    applyStimulus(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1'b0);
    applyStimulus(OP_MULTU, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 0, 1'b1);

    // MTHI in IDLE, then a flushed MULTU must leave HI/LO untouched.
    @(posedge clock); #1;
    bus.hi_we = 1'b1;
    bus.write_data = 32'h12345678;
    @(posedge clock); #1;
    bus.hi_we = 1'b0;
    @(negedge clock);
    checkOutput("mthi_hi", {32'd0, bus.hi}, 64'h12345678);
    checkOutput("mthi_lo", {32'd0, bus.lo}, 64'd6);
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd0, 10, 1'b1);
    checkOutput("flush_hi", {32'd0, bus.hi}, 64'h12345678);
    checkOutput("flush_lo", {32'd0, bus.lo}, 64'd6);

    // Asynchronous reset in the middle of a DIVU.
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.op = OP_DIVU;
    bus.operand_a = 32'd1000;
    bus.operand_b = 32'd3;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (18) @(posedge clock);
    #3;
    checkOutput("prereset_busy", {63'd0, bus.busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("async_reset_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("async_reset_lo", {32'd0, bus.lo}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("no_resume_busy", {63'd0, bus.busy}, 64'd0);
    applyStimulus(OP_MULTU, 32'd5, 32'd5, 32'd0, 32'd25, 0, 1'b0);

    repeat (3) @(posedge clock);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
